// File: rtl/ppu_pkg.sv
// Shared PPU-side types and constants: OAM DMA sequencer states, trigger address and
// PPU register index for OAMDATA.
package ppu_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        GET,
        PUT
    } oam_dma_state_t;

    localparam logic [15:0] OAM_DMA_TRIG_ADDR = 16'h4014;
    localparam logic [2:0]  PPU_AIN_OAMDATA   = 3'd4;
    localparam int unsigned OAM_DMA_BYTES     = 256;

endpackage

// File: rtl/oam_dma_ctrl.sv
// Sprite OAM DMA sequencer: halts the CPU on a $4014 write and copies one CPU page into
// OAMDATA as get/put pairs. Optional OAM_DMA_CYCLE_CNT_EN adds a dma_cycles length report.
module oam_dma_ctrl
    import ppu_pkg::*;
#(
    parameter logic [15:0] TRIG_ADDR   = OAM_DMA_TRIG_ADDR,
    parameter int unsigned OAM_BYTES   = OAM_DMA_BYTES,
    parameter logic [2:0]  OAMDATA_AIN = PPU_AIN_OAMDATA
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce,
    input  logic [15:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [7:0]  cpu_dout,
    output logic        cpu_rdy,
    output logic        busy,
    output logic        bus_rd,
    output logic [15:0] bus_addr,
    input  logic [7:0]  bus_din,
    output logic        ppu_wr,
    output logic [2:0]  ppu_ain,
    output logic [7:0]  ppu_dout
`ifdef OAM_DMA_CYCLE_CNT_EN
    ,
    output logic [9:0]  dma_cycles
`endif
);

    localparam logic [7:0] LAST_IDX = 8'(OAM_BYTES - 1);

    oam_dma_state_t state_q;
    logic           parity_q;
    logic [7:0]     idx_q;
    logic [7:0]     page_q;
    logic [7:0]     data_q;
    logic           trig_hit;

    assign trig_hit = cpu_wr && (cpu_addr == TRIG_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order within the block.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            parity_q <= 1'b0;
            idx_q    <= '0;
            page_q   <= '0;
            data_q   <= '0;
        end else if (ce) begin
            parity_q <= ~parity_q;
            case (state_q)
                IDLE: begin
                    if (trig_hit) begin
                        page_q  <= cpu_dout;
                        idx_q   <= '0;
                        state_q <= HALT;
                    end
                end
                // ALIGN is inserted only when needed so that GET always lands on parity 0.
                HALT:  state_q <= parity_q ? GET : ALIGN;
                ALIGN: state_q <= GET;
                GET: begin
                    data_q  <= bus_din;
                    state_q <= PUT;
                end
                PUT: begin
                    idx_q   <= idx_q + 8'd1;
                    state_q <= (idx_q == LAST_IDX) ? IDLE : GET;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy     = (state_q != IDLE);
    assign cpu_rdy  = ~busy;
    assign bus_rd   = (state_q == GET);
    assign bus_addr = bus_rd ? {page_q, idx_q} : 16'h0000;
    assign ppu_wr   = (state_q == PUT);
    assign ppu_ain  = ppu_wr ? OAMDATA_AIN : 3'd0;
    assign ppu_dout = ppu_wr ? data_q : 8'h00;

`ifdef OAM_DMA_CYCLE_CNT_EN
    logic [9:0] run_q;
    logic [9:0] run_d;
    logic [9:0] total_q;

    assign run_d = run_q + 10'd1;

    // The running count only becomes visible once a transfer finishes its last PUT.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q   <= '0;
            total_q <= '0;
        end else if (ce && busy) begin
            if (state_q == PUT && idx_q == LAST_IDX) begin
                total_q <= run_d;
                run_q   <= '0;
            end else begin
                run_q <= run_d;
            end
        end
    end

    assign dma_cycles = total_q;
`endif

endmodule
